// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RV32 load/store unit. Accepts one pipeline request at a time,
//               drives a word-addressed data memory with byte enables, extracts
//               and sign/zero-extends load data, and reports completion with a
//               one-cycle respValid pulse. A one-cycle GAP state after every
//               access guarantees dmemStoreValid drops between stores.
//               Optional feature macro LSU_MISALIGN_TRAP_EN: misaligned
//               halfword/word accesses trap to a one-cycle FAULT response
//               instead of being truncated to natural alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit (
    input  logic        clock,
    input  logic        reset,
    // pipeline request
    input  logic        reqValid,
    input  logic        reqIsLoad,
    input  logic        reqIsStore,
    input  logic [2:0]  funct3,
    input  logic [31:0] reqAddress,
    input  logic [31:0] reqStoreData,
    // pipeline response
    output logic        reqReady,
    output logic        respValid,
    output logic [31:0] respData,
    output logic        misaligned,
    output logic [31:0] faultAddress,
    // data memory
    output logic [31:0] dmemAddress,
    output logic [31:0] dmemStoreData,
    output logic [3:0]  dmemByteEnable,
    output logic        dmemStoreValid,
    input  logic [31:0] dmemLoadData,
    input  logic        dmemLoadDataValid,
    input  logic        dmemStoreComplete
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_STORE = 3'd2,
        ST_GAP   = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Access width from funct3. The unsigned codes only exist for loads, so a
    // store carrying 100/101 (or any unknown code) is handled as a word.
    function automatic logic [1:0] decode_size(input logic [2:0] code, input logic is_store);
        logic [1:0] size;
        case (code)
            3'b000:  size = SIZE_B;
            3'b001:  size = SIZE_H;
            3'b100:  size = is_store ? SIZE_W : SIZE_B;
            3'b101:  size = is_store ? SIZE_W : SIZE_H;
            default: size = SIZE_W;
        endcase
        return size;
    endfunction

    // Byte offset truncated to the natural alignment of the access size.
    function automatic logic [1:0] natural_offset(input logic [1:0] size, input logic [1:0] a);
        logic [1:0] off;
        case (size)
            SIZE_B:  off = a;
            SIZE_H:  off = {a[1], 1'b0};
            default: off = 2'b00;
        endcase
        return off;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] store_data_q, store_data_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [31:0] fault_address_q, fault_address_d;

    logic        w_req_fire;
    logic [1:0]  w_op_size;
    logic [1:0]  w_offset;
    logic [7:0]  w_load_byte;
    logic [15:0] w_load_half;
    logic [31:0] w_load_result;
    logic [3:0]  w_store_be;
    logic [31:0] w_store_data;

    assign reqReady   = (state_q == ST_IDLE) && !reset;
    assign w_req_fire = reqValid && reqReady && (reqIsLoad || reqIsStore);

    // Size and lane offset of the access currently in flight.
    assign w_op_size = decode_size(funct3_q, state_q == ST_STORE);
    assign w_offset  = natural_offset(w_op_size, addr_q[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    logic [1:0] w_req_size;
    logic       w_req_misaligned;

    assign w_req_size       = decode_size(funct3, reqIsStore);
    assign w_req_misaligned = ((w_req_size == SIZE_H) && reqAddress[0]) ||
                              ((w_req_size == SIZE_W) && (reqAddress[1:0] != 2'b00));
`endif

    // Select the addressed byte / halfword lane of the returned word.
    always_comb begin
        w_load_byte = dmemLoadData[7:0];
        case (w_offset)
            2'd0: w_load_byte = dmemLoadData[7:0];
            2'd1: w_load_byte = dmemLoadData[15:8];
            2'd2: w_load_byte = dmemLoadData[23:16];
            2'd3: w_load_byte = dmemLoadData[31:24];
            default: w_load_byte = dmemLoadData[7:0];
        endcase
        w_load_half = w_offset[1] ? dmemLoadData[31:16] : dmemLoadData[15:0];
    end

    // Sign- or zero-extend the selected lane according to funct3.
    always_comb begin
        case (funct3_q)
            3'b000:  w_load_result = {{24{w_load_byte[7]}}, w_load_byte};
            3'b100:  w_load_result = {24'd0, w_load_byte};
            3'b001:  w_load_result = {{16{w_load_half[15]}}, w_load_half};
            3'b101:  w_load_result = {16'd0, w_load_half};
            default: w_load_result = dmemLoadData;
        endcase
    end

    // Store byte enables and lane-replicated store data.
    always_comb begin
        case (w_op_size)
            SIZE_B: begin
                w_store_be   = 4'b0001 << w_offset;
                w_store_data = {4{store_data_q[7:0]}};
            end
            SIZE_H: begin
                w_store_be   = 4'b0011 << w_offset;
                w_store_data = {2{store_data_q[15:0]}};
            end
            default: begin
                w_store_be   = 4'b1111;
                w_store_data = store_data_q;
            end
        endcase
    end

    // Next-state and register-update logic for the access sequencer.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        funct3_d        = funct3_q;
        store_data_d    = store_data_q;
        resp_data_d     = resp_data_q;
        fault_address_d = fault_address_q;

        case (state_q)
            ST_IDLE: begin
                if (w_req_fire) begin
                    addr_d       = reqAddress;
                    funct3_d     = funct3;
                    store_data_d = reqStoreData;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (w_req_misaligned) begin
                        state_d         = ST_FAULT;
                        resp_data_d     = 32'd0;
                        fault_address_d = reqAddress;
                    end else if (reqIsStore) begin
                        state_d = ST_STORE;
                    end else begin
                        state_d = ST_LOAD;
                    end
`else
                    state_d = reqIsStore ? ST_STORE : ST_LOAD;
`endif
                end
            end
            ST_LOAD: begin
                if (dmemLoadDataValid) begin
                    resp_data_d = w_load_result;
                    state_d     = ST_GAP;
                end
            end
            ST_STORE: begin
                if (dmemStoreComplete) begin
                    resp_data_d = 32'd0;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP:   state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any access in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            addr_q          <= 32'd0;
            funct3_q        <= 3'd0;
            store_data_q    <= 32'd0;
            resp_data_q     <= 32'd0;
            fault_address_q <= 32'd0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            funct3_q        <= funct3_d;
            store_data_q    <= store_data_d;
            resp_data_q     <= resp_data_d;
            fault_address_q <= fault_address_d;
        end
    end

    assign respValid      = (state_q == ST_GAP) || (state_q == ST_FAULT);
    assign respData       = resp_data_q;
    assign faultAddress   = fault_address_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned     = (state_q == ST_FAULT);
`else
    assign misaligned     = 1'b0;
`endif

    assign dmemAddress    = {addr_q[31:2], 2'b00};
    assign dmemStoreValid = (state_q == ST_STORE);
    assign dmemByteEnable = (state_q == ST_STORE) ? w_store_be : 4'b0000;
    assign dmemStoreData  = (state_q == ST_STORE) ? w_store_data : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed, table-driven bench for load_store_unit with a small
//               byte-enabled memory model (store completes one cycle after the
//               rising edge of dmemStoreValid, loads are zero-wait by default).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        reqValid, reqIsLoad, reqIsStore;
    logic [2:0]  funct3;
    logic [31:0] reqAddress, reqStoreData;
    logic        reqReady, respValid, misaligned;
    logic [31:0] respData, faultAddress;
    logic [31:0] dmemAddress, dmemStoreData, dmemLoadData;
    logic [3:0]  dmemByteEnable;
    logic        dmemStoreValid, dmemLoadDataValid, dmemStoreComplete;

    logic        mem_init;
    logic        ld_valid_en;
    logic        extra_complete;
    logic [31:0] mem [0:255];
    logic        stv_prev;
    logic        complete_q;
    int          write_count;

    int total  = 0;
    int passed = 0;

    always #5 clock = ~clock;

    load_store_unit dut (
        .clock             (clock),
        .reset             (reset),
        .reqValid          (reqValid),
        .reqIsLoad         (reqIsLoad),
        .reqIsStore        (reqIsStore),
        .funct3            (funct3),
        .reqAddress        (reqAddress),
        .reqStoreData      (reqStoreData),
        .reqReady          (reqReady),
        .respValid         (respValid),
        .respData          (respData),
        .misaligned        (misaligned),
        .faultAddress      (faultAddress),
        .dmemAddress       (dmemAddress),
        .dmemStoreData     (dmemStoreData),
        .dmemByteEnable    (dmemByteEnable),
        .dmemStoreValid    (dmemStoreValid),
        .dmemLoadData      (dmemLoadData),
        .dmemLoadDataValid (dmemLoadDataValid),
        .dmemStoreComplete (dmemStoreComplete)
    );

    // Memory model: write on the rising edge of dmemStoreValid, ack next cycle.
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            stv_prev    <= 1'b0;
            complete_q  <= 1'b0;
            write_count <= 0;
        end else begin
            complete_q <= 1'b0;
            if (dmemStoreValid && !stv_prev) begin
                for (int b = 0; b < 4; b++)
                    if (dmemByteEnable[b])
                        mem[dmemAddress[9:2]][8*b +: 8] <= dmemStoreData[8*b +: 8];
                complete_q  <= 1'b1;
                write_count <= write_count + 1;
            end
            stv_prev <= dmemStoreValid;
        end
    end

    assign dmemLoadData      = mem[dmemAddress[9:2]];
    assign dmemLoadDataValid = ld_valid_en;
    assign dmemStoreComplete = complete_q | extra_complete;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Issue one request, then watch each cycle until respValid (bounded).
    task automatic op(input logic ld, input logic st, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rdata, output int lat,
                      output logic [3:0] be_seen, output logic [31:0] sd_seen,
                      output logic mis, output logic [31:0] fa,
                      output logic busy_ready, output logic gap_sv);
        @(negedge clock);
        reqValid = 1'b1; reqIsLoad = ld; reqIsStore = st;
        funct3 = f3; reqAddress = addr; reqStoreData = wd;
        @(posedge clock);
        @(negedge clock);
        reqValid = 1'b0; reqIsLoad = 1'b0; reqIsStore = 1'b0;
        lat = 0; be_seen = 4'd0; sd_seen = 32'd0; busy_ready = 1'b0;
        rdata = 32'd0; mis = 1'b0; fa = 32'd0; gap_sv = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            if (reqReady) busy_ready = 1'b1;
            if (respValid) begin
                lat = c; rdata = respData; mis = misaligned; fa = faultAddress;
                gap_sv = dmemStoreValid | (|dmemByteEnable);
                break;
            end
            if (dmemStoreValid) begin
                be_seen = be_seen | dmemByteEnable;
                sd_seen = sd_seen | dmemStoreData;
            end
            @(negedge clock);
        end
    endtask

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_data;
        int          exp_lat;
        logic [3:0]  exp_be;
        logic [31:0] exp_sd;
    } vec_t;

    vec_t vecs[22];

    initial begin
        logic [31:0] rd, fa, sd;
        logic [3:0]  be;
        logic        mis, br, gsv, bad;
        int          lat, wc0;

        vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h100, 32'h8899AABB, 32'h00000000, 3, 4'b1111, 32'h8899AABB};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0,        32'hFFFFFFAA, 2, 4'b0000, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h101, 32'h0,        32'h000000AA, 2, 4'b0000, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0,        32'h00008899, 2, 4'b0000, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'hFFFF8899, 2, 4'b0000, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'h8899AABB, 2, 4'b0000, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'hFFFFFF88, 2, 4'b0000, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 3'b100, 32'h100, 32'h0,        32'h000000BB, 2, 4'b0000, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 3'b001, 32'h100, 32'h0,        32'hFFFFAABB, 2, 4'b0000, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 3'b000, 32'h103, 32'h00000012, 32'h00000000, 3, 4'b1000, 32'h12121212};
        vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'h1299AABB, 2, 4'b0000, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h0000BEEF, 32'h00000000, 3, 4'b1100, 32'hBEEFBEEF};
        vecs[12] = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hBEEFAABB, 2, 4'b0000, 32'h0};
        vecs[13] = '{1'b0, 1'b1, 3'b000, 32'h101, 32'hABCDEF77, 32'h00000000, 3, 4'b0010, 32'h77777777};
        vecs[14] = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hBEEF77BB, 2, 4'b0000, 32'h0};
        vecs[15] = '{1'b0, 1'b1, 3'b001, 32'h100, 32'h12345678, 32'h00000000, 3, 4'b0011, 32'h56785678};
        vecs[16] = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        32'h00005678, 2, 4'b0000, 32'h0};
        vecs[17] = '{1'b0, 1'b1, 3'b100, 32'h104, 32'hCAFEF00D, 32'h00000000, 3, 4'b1111, 32'hCAFEF00D};
        vecs[18] = '{1'b1, 1'b0, 3'b011, 32'h104, 32'h0,        32'hCAFEF00D, 2, 4'b0000, 32'h0};
        vecs[19] = '{1'b1, 1'b0, 3'b000, 32'h106, 32'h0,        32'hFFFFFFFE, 2, 4'b0000, 32'h0};
        vecs[20] = '{1'b1, 1'b0, 3'b101, 32'h106, 32'h0,        32'h0000CAFE, 2, 4'b0000, 32'h0};
        vecs[21] = '{1'b1, 1'b0, 3'b001, 32'h104, 32'h0,        32'hFFFFF00D, 2, 4'b0000, 32'h0};

        reset = 1'b1; mem_init = 1'b1; ld_valid_en = 1'b1; extra_complete = 1'b0;
        reqValid = 1'b0; reqIsLoad = 1'b0; reqIsStore = 1'b0;
        funct3 = 3'd0; reqAddress = 32'd0; reqStoreData = 32'd0;
        repeat (3) @(negedge clock);

        // Reset state
        check("rst reqReady",      {31'd0, reqReady}, 32'd0);
        check("rst respValid",     {31'd0, respValid}, 32'd0);
        check("rst storeValid",    {31'd0, dmemStoreValid}, 32'd0);
        check("rst misaligned",    {31'd0, misaligned}, 32'd0);
        check("rst byteEnable",    {28'd0, dmemByteEnable}, 32'd0);
        check("rst storeData",     dmemStoreData, 32'd0);
        check("rst dmemAddress",   dmemAddress, 32'd0);
        check("rst respData",      respData, 32'd0);
        check("rst faultAddress",  faultAddress, 32'd0);
        reset = 1'b0; mem_init = 1'b0;
        #1;
        check("post-rst reqReady", {31'd0, reqReady}, 32'd1);

        // Request with neither load nor store set is ignored
        @(negedge clock);
        reqValid = 1'b1; reqAddress = 32'h100;
        @(negedge clock);
        reqValid = 1'b0;
        check("ignored req ready", {31'd0, reqReady}, 32'd1);
        check("ignored req sv",    {31'd0, dmemStoreValid}, 32'd0);

        // Table-driven vectors
        for (int i = 0; i < 22; i++) begin
            op(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd,
               rd, lat, be, sd, mis, fa, br, gsv);
            check($sformatf("v%0d respData", i), rd, vecs[i].exp_data);
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d byteEnable", i), {28'd0, be}, {28'd0, vecs[i].exp_be});
            check($sformatf("v%0d storeData", i), sd, vecs[i].exp_sd);
            check($sformatf("v%0d reqReady busy", i), {31'd0, br}, 32'd0);
            check($sformatf("v%0d gap store idle", i), {31'd0, gsv}, 32'd0);
            check($sformatf("v%0d misaligned", i), {31'd0, mis}, 32'd0);
        end

        // Back-to-back word stores: each must produce its own write and pulse
        wc0 = write_count;
        op(1'b0, 1'b1, 3'b010, 32'h200, 32'h11111111, rd, lat, be, sd, mis, fa, br, gsv);
        check("b2b first latency", 32'(lat), 32'd3);
        check("b2b first gap sv",  {31'd0, gsv}, 32'd0);
        op(1'b0, 1'b1, 3'b010, 32'h204, 32'h22222222, rd, lat, be, sd, mis, fa, br, gsv);
        check("b2b second latency", 32'(lat), 32'd3);
        check("b2b write count",    32'(write_count - wc0), 32'd2);
        op(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, rd, lat, be, sd, mis, fa, br, gsv);
        check("b2b word 0x200", rd, 32'h11111111);
        op(1'b1, 1'b0, 3'b010, 32'h204, 32'h0, rd, lat, be, sd, mis, fa, br, gsv);
        check("b2b word 0x204", rd, 32'h22222222);

        // Stray store-complete in IDLE is ignored
        @(negedge clock);
        extra_complete = 1'b1;
        @(negedge clock);
        extra_complete = 1'b0;
        check("stray cmpl respValid", {31'd0, respValid}, 32'd0);
        check("stray cmpl reqReady",  {31'd0, reqReady}, 32'd1);

        // Load waits indefinitely for data valid; stray complete in LOAD ignored
        ld_valid_en = 1'b0;
        reqValid = 1'b1; reqIsLoad = 1'b1; funct3 = 3'b010; reqAddress = 32'h104;
        @(posedge clock);
        @(negedge clock);
        reqValid = 1'b0; reqIsLoad = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (respValid || reqReady) bad = 1'b1;
            extra_complete = (k == 1);
            if (k == 3) ld_valid_en = 1'b1;
            @(negedge clock);
        end
        check("wait no early resp", {31'd0, bad}, 32'd0);
        check("wait respValid",     {31'd0, respValid}, 32'd1);
        check("wait respData",      respData, 32'hCAFEF00D);
        @(negedge clock);
        check("wait single pulse",  {31'd0, respValid}, 32'd0);
        check("respData holds",     respData, 32'hCAFEF00D);

`ifdef LSU_MISALIGN_TRAP_EN
        wc0 = write_count;
        op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, rd, lat, be, sd, mis, fa, br, gsv);
        check("trap LW latency",    32'(lat), 32'd1);
        check("trap LW misaligned", {31'd0, mis}, 32'd1);
        check("trap LW faultAddr",  fa, 32'h00000102);
        check("trap LW respData",   rd, 32'd0);
        check("trap LW no store",   {28'd0, be}, 32'd0);
        op(1'b0, 1'b1, 3'b001, 32'h101, 32'h0000FFFF, rd, lat, be, sd, mis, fa, br, gsv);
        check("trap SH latency",    32'(lat), 32'd1);
        check("trap SH faultAddr",  fa, 32'h00000101);
        check("trap SH no write",   32'(write_count - wc0), 32'd0);
        op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, rd, lat, be, sd, mis, fa, br, gsv);
        check("trap word intact",   rd, 32'hBEEF5678);
`else
        op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, rd, lat, be, sd, mis, fa, br, gsv);
        check("trunc LW data",       rd, 32'hBEEF5678);
        check("trunc LW latency",    32'(lat), 32'd2);
        check("trunc LW misaligned", {31'd0, mis}, 32'd0);
        check("trunc LW faultAddr",  fa, 32'd0);
        op(1'b1, 1'b0, 3'b001, 32'h103, 32'h0, rd, lat, be, sd, mis, fa, br, gsv);
        check("trunc LH data",       rd, 32'hFFFFBEEF);
        op(1'b0, 1'b1, 3'b010, 32'h10A, 32'hA5A5A5A5, rd, lat, be, sd, mis, fa, br, gsv);
        check("trunc SW byteEnable", {28'd0, be}, 32'h0000000F);
`endif

        // Reset during STORE aborts without a response
        @(negedge clock);
        reqValid = 1'b1; reqIsStore = 1'b1; funct3 = 3'b000;
        reqAddress = 32'h300; reqStoreData = 32'h0000005A;
        @(posedge clock);
        @(negedge clock);
        reqValid = 1'b0; reqIsStore = 1'b0;
        check("abort in STORE sv", {31'd0, dmemStoreValid}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("abort sv low",      {31'd0, dmemStoreValid}, 32'd0);
        check("abort no resp",     {31'd0, respValid}, 32'd0);
        check("abort byteEnable",  {28'd0, dmemByteEnable}, 32'd0);
        check("abort dmemAddress", dmemAddress, 32'd0);
        check("abort respData",    respData, 32'd0);
        reset = 1'b0;
        #1;
        check("abort reqReady",    {31'd0, reqReady}, 32'd1);
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (respValid || dmemStoreValid) bad = 1'b1;
        end
        check("abort stays quiet", {31'd0, bad}, 32'd0);
        op(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, rd, lat, be, sd, mis, fa, br, gsv);
        check("recover LW data",    rd, 32'hCAFEF00D);
        check("recover LW latency", 32'(lat), 32'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, checks passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule
`default_nettype wire
